rq_offset_advance: RTL and testbench

// Writer side of the RQOffsetRecord table: the RQ meta/prefetch path only reads per-QP RQ offsets, and this block advances them.

---
 rtl/rq_offset_advance_pkg.sv | 20 ++
 rtl/rq_offset_wrap_calc.sv | 30 +++
 rtl/rq_offset_advance.sv | 105 ++++++++++
 tb/tb_rq_offset_advance.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rq_offset_advance_pkg.sv
// rq_offset_advance_pkg: shared constants, head layout and FSM states for the RQ offset writer
package rq_offset_advance_pkg;
    localparam int QP_NUM_LOG   = 8;
    localparam int QPN_ENTRIES  = 1 << QP_NUM_LOG;
    localparam int OFFSET_WIDTH = 24;
    localparam int UNIT_LOG     = 4;
    localparam int SZ_LOG_MIN   = 4;
    localparam int SZ_LOG_MAX   = 11;
    localparam int HEAD_WIDTH   = 80;

    typedef enum logic [1:0] {INIT_s, IDLE_s, READ_s, WRITE_s} state_t;

    // Packed MSB-first: wqe_num [79:64], rq_length [63:32], sz_log [31:24], qpn [23:0]
    typedef struct packed {
        logic [15:0] wqe_num;
        logic [31:0] rq_length;
        logic [7:0]  sz_log;
        logic [23:0] qpn;
    } consume_head_t;
endpackage

// File: rtl/rq_offset_wrap_calc.sv
// rq_offset_wrap_calc: combinational offset advance with ring wrap and legality check
// i_dout current offset, i_wqe_num/i_sz_log/i_rq_length request fields,
// o_new_offset advanced offset (< limit), o_illegal request must be dropped
module rq_offset_wrap_calc
    import rq_offset_advance_pkg::*;
(
    input  logic [OFFSET_WIDTH-1:0] i_dout,
    input  logic [15:0]             i_wqe_num,
    input  logic [7:0]              i_sz_log,
    input  logic [31:0]             i_rq_length,
    output logic [OFFSET_WIDTH-1:0] o_new_offset,
    output logic                    o_illegal
);
    logic        w_sz_ok;
    logic [2:0]  w_shift;
    logic [31:0] w_inc;
    logic [31:0] w_limit;
    logic [31:0] w_sum;

    assign w_sz_ok = i_sz_log >= 8'(SZ_LOG_MIN) && i_sz_log <= 8'(SZ_LOG_MAX);
    // Shift clamped to 0 for illegal sizes so the datapath stays bounded; result is discarded then
    assign w_shift = w_sz_ok ? 3'(i_sz_log - 8'(UNIT_LOG)) : 3'd0;
    assign w_inc   = 32'(i_wqe_num) << w_shift;
    assign w_limit = i_rq_length >> UNIT_LOG;
    assign w_sum   = 32'(i_dout) + w_inc;
    // inc < limit and dout < limit, so a single subtraction suffices
    assign o_new_offset = OFFSET_WIDTH'(w_sum >= w_limit ? w_sum - w_limit : w_sum);
    assign o_illegal = !w_sz_ok || i_rq_length == 32'd0 ||
                       i_rq_length[UNIT_LOG-1:0] != '0 || w_inc >= w_limit;
endmodule

// File: rtl/rq_offset_advance.sv
// rq_offset_advance: per-QP RQ offset writer with post-reset table sweep
// consume_valid/consume_head/consume_ready request handshake,
// rq_offset_wen/addr/din/dout RAM port (dout 1 cycle after addr),
// consume_done/consume_err 1-cycle result pulses, init_done table zeroed
module rq_offset_advance
    import rq_offset_advance_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    consume_valid,
    input  logic [HEAD_WIDTH-1:0]   consume_head,
    output logic                    consume_ready,
    output logic                    rq_offset_wen,
    output logic [QP_NUM_LOG-1:0]   rq_offset_addr,
    output logic [OFFSET_WIDTH-1:0] rq_offset_din,
    input  logic [OFFSET_WIDTH-1:0] rq_offset_dout,
    output logic                    consume_done,
    output logic                    consume_err,
    output logic                    init_done
);
    state_t                  r_state, w_next;
    logic [QP_NUM_LOG-1:0]   r_cnt;
    logic [QP_NUM_LOG-1:0]   r_qpn;
    logic [15:0]             r_wqe_num;
    logic [7:0]              r_sz_log;
    logic [31:0]             r_rq_length;
    logic [OFFSET_WIDTH-1:0] r_new;
    logic                    r_init_done;
    consume_head_t           w_head;
    logic [OFFSET_WIDTH-1:0] w_new;
    logic                    w_illegal;
    logic                    w_last;
    logic                    w_unused_qpn_hi;

    assign w_head          = consume_head;
    assign w_last          = r_cnt == QP_NUM_LOG'(QPN_ENTRIES - 1);
    assign w_unused_qpn_hi = ^w_head.qpn[23:QP_NUM_LOG];
    assign init_done       = r_init_done;

    rq_offset_wrap_calc u_calc (
        .i_dout       (rq_offset_dout),
        .i_wqe_num    (r_wqe_num),
        .i_sz_log     (r_sz_log),
        .i_rq_length  (r_rq_length),
        .o_new_offset (w_new),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT_s;
            r_cnt       <= '0;
            r_qpn       <= '0;
            r_wqe_num   <= '0;
            r_sz_log    <= '0;
            r_rq_length <= '0;
            r_new       <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == INIT_s) r_cnt <= r_cnt + 1'b1;
            if (r_state == INIT_s && w_last) r_init_done <= 1'b1;
            if (consume_valid && consume_ready) begin
                r_qpn       <= w_head.qpn[QP_NUM_LOG-1:0];
                r_wqe_num   <= w_head.wqe_num;
                r_sz_log    <= w_head.sz_log;
                r_rq_length <= w_head.rq_length;
            end
            if (r_state == READ_s) r_new <= w_new;
        end
    end

    always_comb begin
        w_next         = r_state;
        consume_ready  = 1'b0;
        rq_offset_wen  = 1'b0;
        rq_offset_addr = r_qpn;
        rq_offset_din  = '0;
        consume_done   = 1'b0;
        consume_err    = 1'b0;
        case (r_state)
            INIT_s: begin
                // Gated so nothing is written while reset is held
                rq_offset_wen  = !rst;
                rq_offset_addr = r_cnt;
                if (w_last) w_next = IDLE_s;
            end
            IDLE_s: begin
                consume_ready  = 1'b1;
                rq_offset_addr = w_head.qpn[QP_NUM_LOG-1:0];
                if (consume_valid) w_next = READ_s;
            end
            READ_s: begin
                consume_err = w_illegal;
                w_next      = w_illegal ? IDLE_s : WRITE_s;
            end
            WRITE_s: begin
                rq_offset_wen = 1'b1;
                rq_offset_din = r_new;
                consume_done  = 1'b1;
                w_next        = IDLE_s;
            end
        endcase
    end
endmodule

// File: tb/tb_rq_offset_advance.sv
// tb_rq_offset_advance: directed and randomized checks of the RQ offset writer against an arithmetic model
module tb_rq_offset_advance;
    import rq_offset_advance_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    consume_valid;
    logic [HEAD_WIDTH-1:0]   consume_head;
    logic                    consume_ready;
    logic                    rq_offset_wen;
    logic [QP_NUM_LOG-1:0]   rq_offset_addr;
    logic [OFFSET_WIDTH-1:0] rq_offset_din;
    logic [OFFSET_WIDTH-1:0] rq_offset_dout;
    logic                    consume_done;
    logic                    consume_err;
    logic                    init_done;

    logic                    bd_we;
    logic [QP_NUM_LOG-1:0]   bd_addr;
    logic [OFFSET_WIDTH-1:0] bd_data;
    logic [OFFSET_WIDTH-1:0] mem [QPN_ENTRIES];
    int                      ref_tab [QPN_ENTRIES];
    int                      n_chk = 0;
    int                      n_fail = 0;

    always #5 clk = ~clk;

    rq_offset_advance dut (
        .clk            (clk),
        .rst            (rst),
        .consume_valid  (consume_valid),
        .consume_head   (consume_head),
        .consume_ready  (consume_ready),
        .rq_offset_wen  (rq_offset_wen),
        .rq_offset_addr (rq_offset_addr),
        .rq_offset_din  (rq_offset_din),
        .rq_offset_dout (rq_offset_dout),
        .consume_done   (consume_done),
        .consume_err    (consume_err),
        .init_done      (init_done)
    );

    // Read-first synchronous RAM with a bench backdoor write port
    always @(posedge clk) begin
        if (rq_offset_wen) mem[rq_offset_addr] <= rq_offset_din;
        if (bd_we) mem[bd_addr] <= bd_data;
        rq_offset_dout <= mem[rq_offset_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offset arithmetic straight from the ring rules: advance by inc bytes/16, modulo ring size
    function automatic void model(input int old, input int wqe, input int sz, input int len,
                                  output bit ill, output int nw);
        int inc, lim;
        lim = len / 16;
        ill = sz < 4 || sz > 11 || len == 0 || len % 16 != 0;
        inc = ill ? 0 : wqe * (1 << (sz - 4));
        ill = ill || inc >= lim;
        nw  = ill ? old : (old + inc) % lim;
    endfunction

    task automatic poke(input int a, input int v);
        bd_addr = QP_NUM_LOG'(a);
        bd_data = OFFSET_WIDTH'(v);
        bd_we   = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
        ref_tab[a] = v;
        @(negedge clk);
        #1;
    endtask

    task automatic do_init();
        int bad;
        for (int i = 0; i < QPN_ENTRIES; i++) begin
            chk("init_ready", 32'(consume_ready), 0);
            chk("init_wen", 32'(rq_offset_wen), 1);
            chk("init_din", 32'(rq_offset_din), 0);
            chk("init_addr", 32'(rq_offset_addr), 32'(i));
            chk("init_done_low", 32'(init_done), 0);
            @(negedge clk);
            #1;
        end
        chk("init_end_ready", 32'(consume_ready), 1);
        chk("init_done_high", 32'(init_done), 1);
        bad = 0;
        for (int i = 0; i < QPN_ENTRIES; i++) begin
            if (mem[i] !== '0) bad++;
            ref_tab[i] = 0;
        end
        chk("init_zeroed_entries_bad", 32'(bad), 0);
    endtask

    // Called in an IDLE cycle just after the falling edge; returns in the next IDLE cycle
    task automatic do_req(input int q, input int sz, input int len, input int wqe);
        bit ill;
        int nw, old;
        old = ref_tab[q];
        model(old, wqe, sz, len, ill, nw);
        consume_head  = {16'(wqe), 32'(len), 8'(sz), 24'(q)};
        consume_valid = 1'b1;
        #1;
        chk("idle_ready", 32'(consume_ready), 1);
        chk("idle_addr", 32'(rq_offset_addr), 32'(q));
        @(posedge clk);
        #1 consume_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("read_ready", 32'(consume_ready), 0);
        chk("read_dout", 32'(rq_offset_dout), 32'(old));
        chk("read_err", 32'(consume_err), 32'(ill));
        chk("read_wen", 32'(rq_offset_wen), 0);
        @(negedge clk);
        #1;
        if (!ill) begin
            chk("write_wen", 32'(rq_offset_wen), 1);
            chk("write_addr", 32'(rq_offset_addr), 32'(q));
            chk("write_din", 32'(rq_offset_din), 32'(nw));
            chk("write_done", 32'(consume_done), 1);
            chk("write_ready", 32'(consume_ready), 0);
            ref_tab[q] = nw;
            @(negedge clk);
            #1;
        end else begin
            chk("err_ready", 32'(consume_ready), 1);
            chk("err_wen", 32'(rq_offset_wen), 0);
            chk("err_done", 32'(consume_done), 0);
        end
        chk("table", 32'(mem[q]), 32'(ref_tab[q]));
    endtask

    initial begin
        int q, sz, len, wqe, pick;
        rst           = 1'b1;
        consume_valid = 1'b0;
        consume_head  = '0;
        bd_we         = 1'b0;
        bd_addr       = '0;
        bd_data       = '0;
        poke(3, 24'h55);
        poke(200, 24'hABCDE);
        chk("rst_wen", 32'(rq_offset_wen), 0);
        chk("rst_ready", 32'(consume_ready), 0);
        chk("rst_done", 32'(consume_done), 0);
        chk("rst_err", 32'(consume_err), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_addr", 32'(rq_offset_addr), 0);
        chk("rst_din", 32'(rq_offset_din), 0);

        consume_valid = 1'b1;
        consume_head  = {16'd1, 32'd4096, 8'd4, 24'h2A};
        rst = 1'b0;
        #1;
        do_init();
        consume_valid = 1'b0;

        do_req(5, 6, 4096, 3);
        chk("basic_din12", 32'(mem[5]), 12);
        poke(5, 250);
        do_req(5, 4, 4096, 10);
        chk("wrap_to_4", 32'(mem[5]), 4);
        poke(5, 250);
        do_req(5, 4, 4096, 6);
        chk("wrap_to_0", 32'(mem[5]), 0);

        do_req(7, 4, 4096, 4);
        do_req(7, 4, 4096, 4);
        chk("b2b_final8", 32'(mem[7]), 8);

        poke(5, 17);
        do_req(5, 3, 4096, 1);
        do_req(5, 4, 100, 1);
        do_req(5, 4, 4096, 256);
        do_req(5, 12, 4096, 1);
        do_req(5, 6, 0, 1);
        chk("illegal_unchanged", 32'(mem[5]), 17);

        for (int n = 0; n < 60; n++) begin
            q    = int'($urandom_range(0, 7));
            sz   = int'($urandom_range(3, 12));
            wqe  = int'($urandom_range(0, 63));
            pick = int'($urandom_range(0, 9));
            len  = pick == 0 ? 100 : pick == 1 ? 0 : 16 * (64 << (q % 4));
            do_req(q, sz, len, wqe);
        end

        consume_head  = {16'd2, 32'd4096, 8'd4, 24'd9};
        consume_valid = 1'b1;
        @(posedge clk);
        #1 consume_valid = 1'b0;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("mid_write_wen", 32'(rq_offset_wen), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wen", 32'(rq_offset_wen), 0);
        chk("mid_rst_init_done", 32'(init_done), 0);
        chk("mid_rst_addr", 32'(rq_offset_addr), 0);
        chk("mid_rst_done", 32'(consume_done), 0);
        @(negedge clk);
        #1;
        chk("mid_rst_no_write", 32'(mem[9]), 32'(ref_tab[9]));
        rst = 1'b0;
        #1;
        do_init();
        do_req(9, 5, 1024, 3);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
